// File: rtl/iq_sample_buffer_pkg.sv
// rtl/iq_sample_buffer_pkg.sv - word layout constants, prefetch state encoding and sign-extension helper
package iq_sample_buffer_pkg;

  localparam int IQ_WORD_W       = 32;
  localparam int IQ_HALF_W       = 16;
  localparam int SAMPLE_W_DEF    = 12;
  localparam int ADDR_W_DEF      = 9;
  localparam int BURST_WORDS_DEF = 256;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PRIMING = 2'd1;
  localparam logic [1:0] ST_VALID   = 2'd2;

  // v holds a w-bit sample in its low bits; the bits above are replaced by the sign bit.
  function automatic logic [IQ_HALF_W-1:0] sext_half(input logic [IQ_HALF_W-1:0] v,
                                                     input logic sign, input int w);
    logic [IQ_HALF_W-1:0] keep;
    keep = (IQ_HALF_W'(1) << w) - IQ_HALF_W'(1);
    return sign ? (v | ~keep) : (v & keep);
  endfunction

endpackage

// File: rtl/iq_fifo_ram.sv
// rtl/iq_fifo_ram.sv - simple dual-port RAM with registered read port for the I/Q word FIFO
module iq_fifo_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/iq_sample_buffer.sv
// rtl/iq_sample_buffer.sv - packs I/Q pairs into 32-bit words and buffers them in an FWFT FIFO
module iq_sample_buffer
  import iq_sample_buffer_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int BURST_WORDS = BURST_WORDS_DEF,
  parameter int SAMPLE_W    = SAMPLE_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_s_valid,
  input  logic [SAMPLE_W-1:0]  i_s_i,
  input  logic [SAMPLE_W-1:0]  i_s_q,
  input  logic                 i_rd_en,
  output logic [IQ_WORD_W-1:0] o_rd_data,
  output logic                 o_rd_dr,
  output logic                 o_empty,
  output logic [ADDR_W:0]      o_fill,
  output logic                 o_overflow,
  output logic [15:0]          o_drop_cnt
);

  localparam int FILL_W = ADDR_W + 1;
  localparam logic [FILL_W-1:0] DEPTH = FILL_W'(1) << ADDR_W;
  localparam logic [FILL_W-1:0] BURST = FILL_W'(BURST_WORDS);

  logic                 r_pk_valid;
  logic [IQ_WORD_W-1:0] r_pk_word;
  logic [ADDR_W-1:0]    r_wr_ptr;
  logic [ADDR_W-1:0]    r_rd_ptr;
  logic [FILL_W-1:0]    r_fill;
  logic [1:0]           r_state;
  logic                 r_rd_dr;
  logic                 r_overflow;
  logic [15:0]          r_drop_cnt;

  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [ADDR_W-1:0]    w_rd_addr;
  logic [IQ_WORD_W-1:0] w_ram_q;
  logic [1:0]           w_state_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pk_valid <= 1'b0;
      r_pk_word  <= '0;
    end else begin
      r_pk_valid <= i_s_valid;
      r_pk_word  <= {sext_half(IQ_HALF_W'(i_s_i), i_s_i[SAMPLE_W-1], SAMPLE_W),
                     sext_half(IQ_HALF_W'(i_s_q), i_s_q[SAMPLE_W-1], SAMPLE_W)};
    end
  end

  // A pop at full frees the slot the pending word lands in, so both are honoured.
  assign w_full    = (r_fill == DEPTH);
  assign w_pop     = i_rd_en && (r_state == ST_VALID);
  assign w_push    = r_pk_valid && (!w_full || w_pop);
  assign w_drop    = r_pk_valid && w_full && !w_pop;
  assign w_rd_addr = w_pop ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;

  // Popping the last committed word while its successor is being written needs one priming cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY:   if (w_push) w_state_nxt = ST_PRIMING;
      ST_PRIMING: w_state_nxt = ST_VALID;
      ST_VALID: begin
        if (w_pop) begin
          if (r_fill > FILL_W'(1)) w_state_nxt = ST_VALID;
          else if (w_push)         w_state_nxt = ST_PRIMING;
          else                     w_state_nxt = ST_EMPTY;
        end
      end
      default:    w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_EMPTY;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_rd_dr    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      if (w_push && !w_pop)      r_fill <= r_fill + FILL_W'(1);
      else if (!w_push && w_pop) r_fill <= r_fill - FILL_W'(1);
      r_rd_dr <= (r_fill >= BURST);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  iq_fifo_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (IQ_WORD_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (r_pk_word),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

  assign o_rd_data  = (r_state == ST_VALID) ? w_ram_q : '0;
  assign o_empty    = (r_state != ST_VALID);
  assign o_rd_dr    = r_rd_dr;
  assign o_fill     = r_fill;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_iq_sample_buffer.sv
// tb/tb_iq_sample_buffer.sv - scoreboard bench for iq_sample_buffer with a queue-based reference model
module tb_iq_sample_buffer;

  localparam int ADDR_W = 9;
  localparam int BURST  = 256;
  localparam int DEPTH  = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [11:0] s_i;
  logic [11:0] s_q;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_dr;
  logic        empty;
  logic [9:0]  fill;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  iq_sample_buffer #(.ADDR_W(ADDR_W), .BURST_WORDS(BURST), .SAMPLE_W(12)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_s_valid  (s_valid),
    .i_s_i      (s_i),
    .i_s_q      (s_q),
    .i_rd_en    (rd_en),
    .o_rd_data  (rd_data),
    .o_rd_dr    (rd_dr),
    .o_empty    (empty),
    .o_fill     (fill),
    .o_overflow (overflow),
    .o_drop_cnt (drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_pack(input logic [11:0] i, input logic [11:0] q);
    int si;
    int sq;
    si = (int'(i) >= 2048) ? int'(i) - 4096 : int'(i);
    sq = (int'(q) >= 2048) ? int'(q) - 4096 : int'(q);
    return {16'(si), 16'(sq)};
  endfunction

  // Reference model: tags record the edge each word was stored; a head word is visible one edge later.
  longint      mt[$];
  logic [31:0] sb_q[$];
  bit          m_pk_v;
  logic [31:0] m_pk_w;
  bit          m_vis;
  bit          m_ovf;
  bit          m_rddr;
  int          m_drop;
  longint      cyc = 0;

  always @(posedge clk) begin
    bit do_pop;
    bit do_push;
    int n;
    n = mt.size();
    if (rst) begin
      mt.delete();
      sb_q.delete();
      m_pk_v = 0;
      m_vis  = 0;
      m_ovf  = 0;
      m_rddr = 0;
      m_drop = 0;
    end else begin
      do_pop  = rd_en && m_vis;
      do_push = m_pk_v && (n < DEPTH || do_pop);
      if (m_pk_v && !do_push) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
      if (do_pop) void'(mt.pop_front());
      if (do_push) begin
        mt.push_back(cyc);
        sb_q.push_back(m_pk_w);
      end
      m_rddr = (n >= BURST);
      m_pk_v = s_valid;
      m_pk_w = ref_pack(s_i, s_q);
      m_vis  = (mt.size() > 0) && (mt[0] < cyc);
    end
    cyc++;
  end

  always @(negedge clk) begin
    check("empty", empty, !m_vis);
    check("fill", fill, mt.size());
    check("rd_dr", rd_dr, m_rddr);
    check("overflow", overflow, m_ovf);
    check("drop_cnt", drop_cnt, m_drop);
    if (!empty) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underrun: got word 0x%0h expected none at %0t", rd_data, $time);
      end else begin
        check("rd_data", rd_data, sb_q[0]);
        if (rd_en) void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_sample();
    s_i = 12'($urandom);
    s_q = 12'($urandom);
  endtask

  task automatic drain();
    int budget;
    budget = 2000;
    rd_en = 1;
    while ((fill != 0 || !empty) && budget > 0) begin
      tick();
      budget--;
    end
    rd_en = 0;
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL drain_timeout: got fill %0d expected 0", fill);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; s_valid = 0; rd_en = 0; s_i = 0; s_q = 0;
    tick(); tick();
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_empty", empty, 1);
    check("rst_fill", fill, 0);
    check("rst_rd_dr", rd_dr, 0);

    // extreme sample values and two-cycle latency
    rst = 0; s_valid = 1; s_i = 12'h800; s_q = 12'h7FF;
    tick();
    s_valid = 0;
    tick();
    check("t1_empty_n1", empty, 1);
    tick();
    check("t1_rd_data", rd_data, 32'hF800_07FF);
    check("t1_empty", empty, 0);
    check("t1_fill", fill, 1);
    rd_en = 1; tick(); rd_en = 0;
    check("t1_empty_after_pop", empty, 1);
    check("t1_fill_after_pop", fill, 0);

    // rd_dr threshold
    s_valid = 1;
    for (int k = 0; k < 255; k++) begin rand_sample(); tick(); end
    s_valid = 0; tick(); tick(); tick();
    check("t2_fill_255", fill, 255);
    check("t2_rd_dr_255", rd_dr, 0);
    s_valid = 1; rand_sample(); tick(); s_valid = 0; tick();
    check("t2_fill_256", fill, 256);
    check("t2_rd_dr_lag", rd_dr, 0);
    tick();
    check("t2_rd_dr_set", rd_dr, 1);
    rd_en = 1; tick(); rd_en = 0;
    check("t2_fill_pop", fill, 255);
    check("t2_rd_dr_hold", rd_dr, 1);
    tick();
    check("t2_rd_dr_clr", rd_dr, 0);
    drain();

    // ramp to full, overflow, ordered drain
    rst = 1; tick(); rst = 0;
    s_valid = 1;
    for (int k = 0; k < 512; k++) begin s_i = 12'(k); s_q = ~12'(k); tick(); end
    s_valid = 0; tick(); tick();
    check("t3_fill_full", fill, 512);
    check("t3_no_ovf", overflow, 0);
    check("t3_no_drop", drop_cnt, 0);
    check("t3_head", rd_data, 32'h0000_FFFF);
    s_valid = 1;
    repeat (3) begin rand_sample(); tick(); end
    s_valid = 0; tick(); tick();
    check("t3_ovf", overflow, 1);
    check("t3_drop3", drop_cnt, 3);
    check("t3_fill_still_full", fill, 512);
    drain();
    check("t3_empty_end", empty, 1);

    // sustained push+pop at full
    s_valid = 1;
    for (int k = 0; k < 512; k++) begin rand_sample(); tick(); end
    s_valid = 0; tick(); tick();
    s_valid = 1; rand_sample(); tick();
    rd_en = 1;
    repeat (100) begin
      rand_sample();
      tick();
      check("t4_fill_full", fill, 512);
    end
    s_valid = 0; tick(); rd_en = 0; tick();
    check("t4_fill_end", fill, 512);
    check("t4_drop_same", drop_cnt, 3);

    // reset flush at fill 300 with overflow set
    rd_en = 1; repeat (212) tick(); rd_en = 0;
    check("t6_fill_300", fill, 300);
    check("t6_ovf_pre", overflow, 1);
    rst = 1; tick();
    check("t6_fill", fill, 0);
    check("t6_empty", empty, 1);
    check("t6_rd_dr", rd_dr, 0);
    check("t6_ovf", overflow, 0);
    check("t6_drop", drop_cnt, 0);
    rst = 0;

    // rd_en while empty is ignored
    rd_en = 1;
    repeat (10) begin tick(); check("t5_fill_idle", fill, 0); end
    s_valid = 1; s_i = 12'h123; s_q = 12'hABC; tick();
    s_valid = 0; tick();
    rd_en = 0; tick();
    check("t5_fill", fill, 1);
    check("t5_empty", empty, 0);
    check("t5_word", rd_data, 32'h0123_FABC);
    repeat (3) tick();
    check("t5_fill_held", fill, 1);
    rd_en = 1; tick(); rd_en = 0;
    check("t5_fill_popped", fill, 0);
    check("t5_empty_popped", empty, 1);

    // randomized traffic with rare resets
    for (int ph = 0; ph < 3; ph++) begin
      int pp;
      int pr;
      pp = (ph == 0) ? 90 : ((ph == 1) ? 50 : 20);
      pr = (ph == 0) ? 30 : ((ph == 1) ? 50 : 80);
      repeat (1200) begin
        s_valid = ($urandom_range(99) < pp);
        rd_en   = ($urandom_range(99) < pr);
        rst     = ($urandom_range(999) == 0);
        rand_sample();
        tick();
      end
    end
    s_valid = 0; rd_en = 0; rst = 0;
    tick(); tick();
    drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
